// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-side and response signals of the ALU operation sequencer.
// The master side issues requests, supplies ALU results and consumes responses.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_c_lo;
  logic [DATA_W-1:0] alu_c_hi;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_lo;
  logic [DATA_W-1:0] rsp_hi;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_c_lo, alu_c_hi, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_c_lo, alu_c_hi, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of a 32-bit ALU: holds operands for the
// op-dependent settle time, captures the result and returns it with a handshake.
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic              clock,
  input logic              clear,
  alu_op_sequencer_if.slave bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_load;
  logic              accept, req_err, rsp_fire;

  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_lo_q, rsp_hi_q;
  logic [3:0]        alu_ctrl_q;
  logic              rsp_valid_q, rsp_err_q;

  assign accept   = bus.req_valid && (state == IDLE);
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  always_comb begin
    req_err = (bus.req_op >= 4'd12) || ((bus.req_op == 4'd11) && (bus.req_b == '0));
    case (bus.req_op)
      4'd10:   cnt_load = CNT_W'(MUL_CYCLES - 1);
      4'd11:   cnt_load = CNT_W'(DIV_CYCLES - 1);
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_err ? RESP : EXEC;
      EXEC:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a_q    <= bus.req_a;
            alu_b_q    <= bus.req_b;
            alu_ctrl_q <= bus.req_op;
            cnt        <= req_err ? '0 : cnt_load;
            if (req_err) begin
              rsp_lo_q  <= '0;
              rsp_hi_q  <= '0;
              rsp_err_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_lo_q    <= bus.alu_c_lo;
            rsp_hi_q    <= (alu_ctrl_q >= 4'd10) ? bus.alu_c_hi : '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Error path enters RESP with valid low; raising it here gives the
          // same one-cycle accept-to-valid latency as a single-cycle op.
          if (rsp_fire)         rsp_valid_q <= 1'b0;
          else if (!rsp_valid_q) rsp_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lo    = rsp_lo_q;
  assign bus.rsp_hi    = rsp_hi_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU whose
// multicycle results are only correct once its inputs have settled long enough.
module tb_alu_op_sequencer;
  localparam int DW   = 32;
  localparam int MULC = 4;
  localparam int DIVC = 8;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rr_mode = 0;

  alu_op_sequencer_if #(.DATA_W(DW)) bus ();

  alu_op_sequencer #(.DATA_W(DW), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];

  // ALU: ops 0 and,1 or,2 add,3 sub,4 xor,5 sll,6 srl,7 sra,8 slt,9 ror,10 mul,11 div
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    logic [31:0] lo;
    logic [31:0] hi;
    hi = a ^ b ^ 32'h5A5A_0001;
    case (op)
      4'd0:  lo = a & b;
      4'd1:  lo = a | b;
      4'd2:  lo = a + b;
      4'd3:  lo = a - b;
      4'd4:  lo = a ^ b;
      4'd5:  lo = a << b[4:0];
      4'd6:  lo = a >> b[4:0];
      4'd7:  lo = 32'($signed(a) >>> b[4:0]);
      4'd8:  lo = {31'b0, ($signed(a) < $signed(b))};
      4'd9:  begin t = {a, a} >> b[4:0]; lo = t[31:0]; end
      4'd10: begin t = {32'b0, a} * {32'b0, b}; lo = t[31:0]; hi = t[63:32]; end
      4'd11: begin
        if (b != 0) begin lo = a / b; hi = a % b; end
        else begin lo = '1; hi = a; end
      end
      default: lo = 32'hDEAD_BEEF;
    endcase
    return {hi, lo};
  endfunction

  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t        e;
    logic [63:0] r;
    e.acc = acc;
    if (op >= 12 || (op == 11 && b == 0)) begin
      e.lo = 0; e.hi = 0; e.err = 1'b1; e.lat = 1;
    end else begin
      r     = alu_fn(op, a, b);
      e.lo  = r[31:0];
      e.hi  = (op >= 10) ? r[63:32] : 32'h0;
      e.err = 1'b0;
      e.lat = (op == 10) ? MULC : (op == 11) ? DIVC : 1;
    end
    return e;
  endfunction

  // Behavioural ALU: result is garbage until inputs have been held long enough
  int          hold = 0;
  logic [67:0] prev_in = '0;
  logic [63:0] alu_r;
  int          alu_need;

  always @(negedge clock) begin
    if ({bus.alu_ctrl, bus.alu_a, bus.alu_b} !== prev_in) hold = 0;
    else hold = hold + 1;
    prev_in = {bus.alu_ctrl, bus.alu_a, bus.alu_b};
  end

  always @* begin
    alu_r    = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    alu_need = (bus.alu_ctrl == 4'd10) ? MULC : (bus.alu_ctrl == 4'd11) ? DIVC : 1;
    if (hold >= alu_need - 1) {bus.alu_c_hi, bus.alu_c_lo} = alu_r;
    else {bus.alu_c_hi, bus.alu_c_lo} = alu_r ^ 64'hA5A5_5A5A_DEAD_BEEF;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  logic [31:0] ea = '0, eb = '0;
  logic [3:0]  eop = '0;
  logic        in_resp = 1'b0;
  logic [64:0] held = '0;

  always @(negedge clock) begin
    if (!clear) begin
      check("rst_valid_err_ready_busy",
            {92'b0, bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.busy}, 96'b0010);
      check("rst_alu_ab", {32'b0, bus.alu_a, bus.alu_b}, 96'b0);
      check("rst_alu_ctrl", {92'b0, bus.alu_ctrl}, 96'b0);
      check("rst_rsp_lohi", {32'b0, bus.rsp_lo, bus.rsp_hi}, 96'b0);
      q.delete();
      in_resp = 1'b0;
      ea = '0; eb = '0; eop = '0;
    end else begin
      check("req_ready", {95'b0, bus.req_ready}, {95'b0, (q.size() == 0)});
      check("busy", {95'b0, bus.busy}, {95'b0, (q.size() != 0)});
      check("alu_hold", {28'b0, bus.alu_ctrl, bus.alu_a, bus.alu_b}, {28'b0, eop, ea, eb});
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL stale_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          if (!in_resp) begin
            in_resp = 1'b1;
            held    = {bus.rsp_lo, bus.rsp_hi, bus.rsp_err};
            check("rsp_latency", 96'(cyc), 96'(q[0].acc + q[0].lat));
            check("rsp_lo", {64'b0, bus.rsp_lo}, {64'b0, q[0].lo});
            check("rsp_hi", {64'b0, bus.rsp_hi}, {64'b0, q[0].hi});
            check("rsp_err", {95'b0, bus.rsp_err}, {95'b0, q[0].err});
          end else begin
            check("rsp_stable", {31'b0, bus.rsp_lo, bus.rsp_hi, bus.rsp_err}, {31'b0, held});
          end
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            in_resp = 1'b0;
          end
        end
      end else if (q.size() != 0 && cyc > q[0].acc + q[0].lat) begin
        tests++; fails++;
        $display("FAIL rsp_timeout: got no rsp_valid expected at cycle %0d (cycle %0d)",
                 q[0].acc + q[0].lat, cyc);
        void'(q.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        q.push_back(ref_model(bus.req_op, bus.req_a, bus.req_b, cyc + 1));
        ea = bus.req_a; eb = bus.req_b; eop = bus.req_op;
      end
    end
  end

  // Response-ready driver: 0 = always 1, 1 = random, 2 = always 0
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (bus.req_ready) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 400 cycles (op %0d)", op);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    bus.req_op = 4'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    #1 clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;

    issue(4'd2, 32'd5, 32'd7);                      // add
    idle(3);
    issue(4'd10, 32'h0001_0000, 32'h0001_0000);      // mul into the high word
    idle(1);
    issue(4'd11, 32'd123, 32'd0);                    // divide by zero
    idle(1);
    issue(4'd13, 32'd1, 32'd2);                      // illegal op
    idle(1);

    // consumer stalls while another request waits
    rr_mode = 2;
    issue(4'd2, 32'd20, 32'd22);
    bus.req_op = 4'd4; bus.req_a = 32'hFFFF_0000; bus.req_b = 32'h0F0F_0F0F;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    rr_mode = 0;
    issue(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F);
    idle(2);

    // back-to-back with req_valid held high
    issue(4'd3, 32'd9, 32'd4);
    issue(4'd9, 32'h1234_5678, 32'd8);
    idle(2);

    // reset during a divide
    issue(4'd11, 32'd1000, 32'd7);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #3 clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    idle(20);

    rr_mode = 1;
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b & 32'h0000_00FF;
      issue(op, a, b);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    rr_mode = 0;
    idle(30);
    check("scoreboard_drained", 96'(q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
